// File: rtl/draw_pkg.sv
// Shared drawing types and default widths for the rectangle pipeline.
// Combinational: constants and the FSM state type only, so no latency and no flow control.
package draw_pkg;

    localparam int COORD_W  = 10;
    localparam int COLOR_W  = 3;
    localparam int BG_COLOR = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Column-major i/j scan over a w x h rectangle; j is the fast index, and load clears both counters.
// Each advance moves one position on the next cycle; the scan holds while advance is low and parks at last.
module rect_scan_counter #(
    parameter int SIZE_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              advance,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    output logic [SIZE_W-1:0] i,
    output logic [SIZE_W-1:0] j,
    output logic              last
);

    logic [SIZE_W-1:0] i_q, i_d;
    logic [SIZE_W-1:0] j_q, j_d;
    logic              col_end;

    assign col_end = (j_q == h - SIZE_W'(1));
    assign last    = col_end && (i_q == w - SIZE_W'(1));
    assign i       = i_q;
    assign j       = j_q;

    // Parking on the last pixel keeps x_out/y_out steady after the draw.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (load) begin
            i_d = '0;
            j_d = '0;
        end else if (advance && !last) begin
            if (col_end) begin
                i_d = i_q + SIZE_W'(1);
                j_d = '0;
            end else begin
                j_d = j_q + SIZE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule

// File: rtl/rect_draw.sv
// Rectangle filler: first pixel 1 cycle after start, done w*h+1 cycles after start; each pixel waits for wr_ready.
// With RECT_DRAW_CLIP_EN defined, off-screen pixels are skipped in one cycle with wr_en low.
module rect_draw #(
    parameter int COORD_W  = draw_pkg::COORD_W,
    parameter int SIZE_W   = 10,
    parameter int COLOR_W  = draw_pkg::COLOR_W,
    parameter int BG_COLOR = draw_pkg::BG_COLOR,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [SIZE_W-1:0]  w_in,
    input  logic [SIZE_W-1:0]  h_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               erase,
    input  logic               wr_ready,
    output logic               wr_en,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               busy,
    output logic               done
);

    import draw_pkg::*;

    localparam int PW = COORD_W + 1;

`ifdef RECT_DRAW_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    draw_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [SIZE_W-1:0]  w_q, w_d, h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [SIZE_W-1:0]  i, j;
    logic               last, load, advance, clipped;
    logic [PW-1:0]      px, py;

    rect_scan_counter #(.SIZE_W(SIZE_W)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .advance (advance),
        .w       (w_q),
        .h       (h_q),
        .i       (i),
        .j       (j),
        .last    (last)
    );

    // Extra bit keeps the untruncated sum for the screen-edge test; outputs wrap.
    assign px        = PW'(x_q) + PW'(i);
    assign py        = PW'(y_q) + PW'(j);
    assign clipped   = CLIP_EN && ((px >= PW'(SCREEN_W)) || (py >= PW'(SCREEN_H)));
    assign wr_en     = (state_q == DRAW) && !clipped;
    assign advance   = (state_q == DRAW) && (wr_ready || clipped);
    assign x_out     = px[COORD_W-1:0];
    assign y_out     = py[COORD_W-1:0];
    assign color_out = color_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Empty rectangles leave the operand registers alone so the outputs hold.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_in == '0 || h_in == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAW;
                        load    = 1'b1;
                        x_d     = x_in;
                        y_d     = y_in;
                        w_d     = w_in;
                        h_d     = h_in;
                        color_d = erase ? COLOR_W'(BG_COLOR) : color_in;
                    end
                end
            end
            DRAW: begin
                if (advance && last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_rect_draw.sv
// Bench for rect_draw: directed corner cases plus randomized rectangles and sink backpressure.
// Expected pixels come from a nested-loop reference list; define RECT_DRAW_CLIP_EN to cover clipping.
module tb_rect_draw;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic [9:0] w_in = '0;
    logic [9:0] h_in = '0;
    logic [2:0] color_in = '0;
    logic       erase = 1'b0;
    logic       wr_ready = 1'b1;
    logic       wr_en;
    logic [9:0] x_out, y_out;
    logic [2:0] color_out;
    logic       busy, done;

    int   total = 0;
    int   bad = 0;
    pix_t exp_q[$];

    rect_draw dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .w_in      (w_in),
        .h_in      (h_in),
        .color_in  (color_in),
        .erase     (erase),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        x_in     = 10'($urandom);
        y_in     = 10'($urandom);
        w_in     = 10'($urandom);
        h_in     = 10'($urandom);
        color_in = 3'($urandom);
        erase    = 1'($urandom);
    endtask

    // rmode: 0 = sink always ready, 1 = random ready, 2 = 3-cycle stall on the 2nd pixel
    task automatic run_rect(input int x, input int y, input int w, input int h, input int c,
                            input int er, input int rmode, input int midstart);
        pix_t p;
        int   cyc, exp_done, accepted, stall_left;
        bit   seen_done, prev_stall, clip;
        int   hx, hy, hc;
        exp_q.delete();
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < h; j++) begin
                clip = 1'b0;
`ifdef RECT_DRAW_CLIP_EN
                clip = (x + i >= SCR_W) || (y + j >= SCR_H);
`endif
                if (!clip) begin
                    p.x = (x + i) % 1024;
                    p.y = (y + j) % 1024;
                    p.c = (er != 0) ? 0 : c;
                    exp_q.push_back(p);
                end
            end
        end
        exp_done = (w == 0 || h == 0) ? 1 : w * h + 1;

        x_in = 10'(x); y_in = 10'(y); w_in = 10'(w); h_in = 10'(h);
        color_in = 3'(c); erase = 1'(er); wr_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        cyc = 1; seen_done = 1'b0; prev_stall = 1'b0; accepted = 0; stall_left = 3;
        hx = 0; hy = 0; hc = 0;
        while (!seen_done && cyc < 300) begin
            if (done) begin
                seen_done = 1'b1;
                check("wr_en_in_done", wr_en, 0);
            end else begin
                check("busy", busy, 1);
                case (rmode)
                    0: wr_ready = 1'b1;
                    1: wr_ready = ($urandom_range(3) != 0);
                    default: begin
                        if (wr_en && accepted == 1 && stall_left > 0) begin
                            wr_ready = 1'b0;
                            stall_left--;
                        end else begin
                            wr_ready = 1'b1;
                        end
                    end
                endcase
                if (prev_stall) begin
                    check("hold_wr_en", wr_en, 1);
                    check("hold_x", x_out, hx);
                    check("hold_y", y_out, hy);
                    check("hold_c", color_out, hc);
                end
                prev_stall = wr_en && !wr_ready;
                hx = x_out; hy = y_out; hc = color_out;
                if (wr_en && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", 1, 0);
                    end else begin
                        p = exp_q.pop_front();
                        check("pix_x", x_out, p.x);
                        check("pix_y", y_out, p.y);
                        check("pix_c", color_out, p.c);
                    end
                    accepted++;
                end
                if (midstart != 0 && cyc == 2) begin
                    scramble_inputs();
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        check("done_seen", seen_done, 1);
        if (rmode == 0) check("done_latency", cyc, exp_done);
        check("missing_pixels", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        check("start_not_queued", busy, 0);
        check("idle_wr_en", wr_en, 0);
    endtask

    initial begin
        int cnt, guard;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_c", color_out, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_rect(5, 7, 2, 3, 5, 0, 0, 0);
        run_rect(3, 3, 0, 4, 6, 0, 0, 0);
        run_rect(10, 20, 2, 2, 2, 0, 2, 0);
        run_rect(30, 40, 3, 2, 7, 1, 0, 1);
        run_rect(1020, 1022, 6, 3, 4, 0, 0, 0);

        // reset after the 3rd accepted pixel of a 4x4 draw
        x_in = 10'd50; y_in = 10'd60; w_in = 10'd4; h_in = 10'd4;
        color_in = 3'd3; erase = 1'b0; wr_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 3 && guard < 50) begin
            if (wr_en) cnt++;
            guard++;
            @(posedge clk); #1;
        end
        check("pre_reset_pixels", cnt, 3);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_x", x_out, 0);
        resetn = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_reset_wr_en", wr_en, 0);
            check("post_reset_done", done, 0);
        end

`ifdef RECT_DRAW_CLIP_EN
        run_rect(158, 0, 4, 1, 1, 0, 0, 0);
        run_rect(155, 115, 8, 8, 2, 0, 1, 0);
`endif

        for (int k = 0; k < 20; k++) begin
            int rx, ry;
            rx = ($urandom_range(1) != 0) ? $urandom_range(1023) : $urandom_range(150, 165);
            ry = ($urandom_range(1) != 0) ? $urandom_range(1023) : $urandom_range(110, 125);
            run_rect(rx, ry, $urandom_range(5), $urandom_range(5), $urandom_range(7),
                     $urandom_range(1), ($urandom_range(2) == 0) ? 0 : 1, $urandom_range(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
